// File: rtl/sdram_tester_pkg.sv
// sdram_tester_pkg: shared state encoding and LFSR helper for sdram_tester.
package sdram_tester_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    WR_WAIT,
    RD_ISSUE,
    RD_WAIT,
    DONE
  } state_t;

  localparam logic [15:0] LfsrTaps = 16'hB400;

  // Galois LFSR, right shift: feed the dropped bit back through the tap mask.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? LfsrTaps : 16'h0000);
  endfunction

endpackage

// File: rtl/sdram_tester.sv
// sdram_tester: writes an LFSR pattern over words 0..WordCount-1 through the
// SDRAM controller command port, reads it back and reports pass/fail.
// Optional build macro SDRAM_TESTER_STOP_ON_ERR_EN: finish on first mismatch.
module sdram_tester
  import sdram_tester_pkg::*;
#(
  parameter int unsigned AddrWidth     = 23,
  parameter int unsigned WordCount     = 8388608,
  parameter logic [15:0] Seed          = 16'hACE1,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                 clk,
  input  logic                 rst_,
  input  logic                 start,
  output logic                 cmdTrigger,
  output logic [AddrWidth-1:0] cmdAddr,
  output logic                 cmdWrite,
  output logic [15:0]          cmdWriteData,
  input  logic [15:0]          cmdReadData,
  input  logic                 cmdDone,
  output logic                 busy,
  output logic                 pass,
  output logic                 fail,
  output logic                 timeout,
  output logic [15:0]          errCount,
  output logic [AddrWidth-1:0] failAddr
);

  localparam int unsigned          WdWidth  = $clog2(TimeoutCycles) + 1;
  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(WordCount - 1);
  localparam logic [WdWidth-1:0]   WdLast   = WdWidth'(TimeoutCycles - 1);

  state_t               state, state_n;
  logic [AddrWidth-1:0] addr;
  logic [15:0]          lfsr;
  logic [WdWidth-1:0]   wd_cnt;
  logic                 cmd_seen;
  logic                 err_hit;
  logic                 wd_expire;
  logic                 is_last;
  logic                 blank;
  logic                 wd_hit;

  assign is_last = (addr == LastAddr);
  // The watchdog restarts on every state entry, so a zero count inside a
  // WAIT state marks the blanking cycle right after the trigger.
  assign blank   = (wd_cnt == '0);
  assign wd_hit  = (wd_cnt == WdLast);

  assign cmdAddr      = addr;
  assign cmdWriteData = lfsr;
  assign cmdWrite     = (state == WR_ISSUE) || (state == WR_WAIT);

  // State register.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state, command strobe and completion/timeout decode.
  always_comb begin
    state_n    = state;
    cmdTrigger = 1'b0;
    cmd_seen   = 1'b0;
    err_hit    = 1'b0;
    wd_expire  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_n = WR_ISSUE;
      end
      WR_ISSUE, RD_ISSUE: begin
        if (cmdDone) begin
          cmdTrigger = 1'b1;
          state_n    = (state == WR_ISSUE) ? WR_WAIT : RD_WAIT;
        end else if (wd_hit) begin
          wd_expire = 1'b1;
          state_n   = DONE;
        end
      end
      WR_WAIT: begin
        if (!blank && cmdDone) begin
          cmd_seen = 1'b1;
          state_n  = is_last ? RD_ISSUE : WR_ISSUE;
        end else if (wd_hit) begin
          wd_expire = 1'b1;
          state_n   = DONE;
        end
      end
      RD_WAIT: begin
        if (!blank && cmdDone) begin
          cmd_seen = 1'b1;
          err_hit  = (cmdReadData != lfsr);
          state_n  = is_last ? DONE : RD_ISSUE;
`ifdef SDRAM_TESTER_STOP_ON_ERR_EN
          if (cmdReadData != lfsr) state_n = DONE;
`endif
        end else if (wd_hit) begin
          wd_expire = 1'b1;
          state_n   = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Address/LFSR sequencing, watchdog, error capture and run status.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      addr     <= '0;
      lfsr     <= '0;
      wd_cnt   <= '0;
      busy     <= 1'b0;
      pass     <= 1'b0;
      fail     <= 1'b0;
      timeout  <= 1'b0;
      errCount <= '0;
      failAddr <= '0;
    end else begin
      if (state_n != state || state == IDLE || state == DONE) wd_cnt <= '0;
      else                                                    wd_cnt <= wd_cnt + 1'b1;

      if (state == IDLE && start) begin
        addr     <= '0;
        lfsr     <= Seed;
        busy     <= 1'b1;
        pass     <= 1'b0;
        fail     <= 1'b0;
        timeout  <= 1'b0;
        errCount <= '0;
        failAddr <= '0;
      end

      if (cmd_seen) begin
        if (is_last) begin
          addr <= '0;
          lfsr <= Seed;
        end else begin
          addr <= addr + 1'b1;
          lfsr <= lfsr_next(lfsr);
        end
      end

      if (err_hit) begin
        if (errCount != '1) errCount <= errCount + 1'b1;
        if (errCount == '0) failAddr <= addr;
      end

      if (wd_expire) timeout <= 1'b1;

      if (state_n == DONE) begin
        busy <= 1'b0;
        pass <= !wd_expire && (errCount == '0) && !err_hit;
        fail <= wd_expire || (errCount != '0) || err_hit;
      end
    end
  end

endmodule

// File: tb/tb_sdram_tester.sv
// tb_sdram_tester: table-driven and randomized runs against a behavioural
// SDRAM controller model with configurable busy time and read corruption.
module tb_sdram_tester;

  localparam int unsigned AW   = 8;
  localparam int unsigned WC   = 4;
  localparam int unsigned TOUT = 24;

  logic          clk = 1'b0;
  logic          rst_ = 1'b0;
  logic          start = 1'b0;
  logic          cmdTrigger;
  logic [AW-1:0] cmdAddr;
  logic          cmdWrite;
  logic [15:0]   cmdWriteData;
  logic [15:0]   cmdReadData = '0;
  logic          cmdDone;
  logic          busy, pass, fail, timeout;
  logic [15:0]   errCount;
  logic [AW-1:0] failAddr;

  sdram_tester #(
    .AddrWidth(AW), .WordCount(WC), .Seed(16'hACE1), .TimeoutCycles(TOUT)
  ) dut (
    .clk(clk), .rst_(rst_), .start(start),
    .cmdTrigger(cmdTrigger), .cmdAddr(cmdAddr), .cmdWrite(cmdWrite),
    .cmdWriteData(cmdWriteData), .cmdReadData(cmdReadData), .cmdDone(cmdDone),
    .busy(busy), .pass(pass), .fail(fail), .timeout(timeout),
    .errCount(errCount), .failAddr(failAddr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } cmd_t;

  typedef struct {
    int unsigned blo;
    int unsigned bhi;
    int unsigned low_start;
    logic [3:0]  mask;
    logic [15:0] bad_val;
    int unsigned exp_err;
    int unsigned exp_faddr;
  } vec_t;

  logic [15:0] pat [4] = '{16'hACE1, 16'hE270, 16'h7138, 16'h389C};

  // Controller model configuration (written by the stimulus process).
  int unsigned busy_lo = 2, busy_hi = 2;
  logic [3:0]  bad_mask = '0;
  logic [15:0] bad_val = '0;
  logic        force_low = 1'b0;

  // Controller model state (written only by the model process).
  logic        mdl_done = 1'b1;
  cmd_t        log_q[$];
  cmd_t        cur;
  logic [15:0] mem [4];
  int unsigned cnt;
  logic        pending = 1'b0;
  logic        tail = 1'b0;
  logic [15:0] rd;
  int unsigned viol_low = 0, viol_unst = 0;

  assign cmdDone = mdl_done & ~force_low;

  // Ideal controller: busy for a random number of cycles after each trigger.
  always @(posedge clk) begin
    if (tail) begin
      tail = 1'b0;
      if ({cmdWrite, cmdAddr, cmdWriteData} != {cur.wr, cur.addr, cur.data}) viol_unst++;
    end
    if (cmdTrigger) begin
      if (!cmdDone) viol_low++;
      cur = '{wr: cmdWrite, addr: cmdAddr, data: cmdWriteData};
      log_q.push_back(cur);
      if (cmdWrite && cmdAddr < AW'(4)) mem[cmdAddr[1:0]] = cmdWriteData;
      cnt = $urandom_range(busy_hi, busy_lo);
      pending = 1'b1;
      #1 mdl_done = 1'b0;
    end else if (pending) begin
      if ({cmdWrite, cmdAddr, cmdWriteData} != {cur.wr, cur.addr, cur.data}) viol_unst++;
      cnt--;
      if (cnt == 0) begin
        pending = 1'b0;
        tail = 1'b1;
        rd = (cur.addr < AW'(4)) ? mem[cur.addr[1:0]] : 16'h0000;
        if (!cur.wr && cur.addr < AW'(4) && bad_mask[cur.addr[1:0]]) rd = bad_val;
        #1 mdl_done = 1'b1;
        cmdReadData = rd;
      end
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check(name, {63'd0, busy}, 64'd0);
  endtask

  // One full run; expectations are derived from the vector's fault description.
  task automatic run_vec(input vec_t v, input string name);
    int          base, vl0, vu0, nexp, nreads, bad_idx;
    int unsigned e_err;
    logic        e_fail;
    cmd_t        c;
    base = log_q.size();
    vl0 = viol_low;
    vu0 = viol_unst;
    busy_lo = v.blo;
    busy_hi = v.bhi;
    bad_mask = v.mask;
    bad_val = v.bad_val;
    force_low = (v.low_start != 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, ".busy_set"}, {63'd0, busy}, 64'd1);
    if (v.low_start != 0) begin
      repeat (v.low_start) @(negedge clk);
      check({name, ".no_trig_while_low"}, 64'(log_q.size() - base), 64'd0);
      force_low = 1'b0;
      #1;
    end
    check({name, ".first_trig"}, {63'd0, cmdTrigger}, 64'd1);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle({name, ".finish"});
`ifdef SDRAM_TESTER_STOP_ON_ERR_EN
    e_err  = (v.exp_err > 0) ? 1 : 0;
    nreads = (v.exp_err > 0) ? int'(v.exp_faddr) + 1 : WC;
`else
    e_err  = v.exp_err;
    nreads = WC;
`endif
    e_fail = (v.exp_err > 0);
    nexp = WC + nreads;
    check({name, ".pass"}, {63'd0, pass}, {63'd0, !e_fail});
    check({name, ".fail"}, {63'd0, fail}, {63'd0, e_fail});
    check({name, ".timeout"}, {63'd0, timeout}, 64'd0);
    check({name, ".errCount"}, 64'(errCount), 64'(e_err));
    check({name, ".failAddr"}, 64'(failAddr), (v.exp_err > 0) ? 64'(v.exp_faddr) : 64'd0);
    repeat (4) @(negedge clk);
    check({name, ".trig_count"}, 64'(log_q.size() - base), 64'(nexp));
    bad_idx = -1;
    for (int i = 0; i < nexp && base + i < log_q.size(); i++) begin
      c = log_q[base + i];
      if (c.wr != (i < WC) || c.addr != AW'(i % WC) ||
          (i < WC && c.data != pat[i % WC])) begin
        if (bad_idx < 0) bad_idx = i;
      end
    end
    check({name, ".cmd_sequence_first_bad"}, 64'(bad_idx), 64'hFFFF_FFFF_FFFF_FFFF);
    check({name, ".trig_while_done_low"}, 64'(viol_low - vl0), 64'd0);
    check({name, ".cmd_stable"}, 64'(viol_unst - vu0), 64'd0);
    check({name, ".status_hold"}, {62'd0, pass, fail}, {62'd0, !e_fail, e_fail});
  endtask

  vec_t vecs [6];
  vec_t rv;
  int   base, n;

  initial begin
    //            blo bhi low  mask     bad_val   err faddr
    vecs[0] = '{2,  2,  0,  4'b0000, 16'h0000, 0,  0};
    vecs[1] = '{2,  2,  0,  4'b0100, 16'h0000, 1,  2};
    vecs[2] = '{1,  20, 0,  4'b0000, 16'h0000, 0,  0};
    vecs[3] = '{1,  5,  10, 4'b1010, 16'hFFFF, 2,  1};
    vecs[4] = '{1,  1,  0,  4'b1111, 16'h7138, 3,  0};
    vecs[5] = '{3,  9,  0,  4'b1000, 16'h389D, 1,  3};

    repeat (3) @(negedge clk);
    check("reset_outputs", {cmdTrigger, cmdAddr, cmdWrite, cmdWriteData, busy, pass, fail,
                            timeout, errCount, failAddr}, 64'd0);
    rst_ = 1'b1;
    @(negedge clk);
    check("post_reset_outputs", {cmdTrigger, cmdAddr, cmdWrite, cmdWriteData, busy, pass, fail,
                                 timeout, errCount, failAddr}, 64'd0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Randomized faults, expected result computed from the corrupted words.
    for (int r = 0; r < 4; r++) begin
      rv.blo = $urandom_range(4, 1);
      rv.bhi = rv.blo + $urandom_range(16, 0);
      rv.low_start = ($urandom_range(1, 0) != 0) ? $urandom_range(12, 1) : 0;
      rv.mask = 4'($urandom_range(15, 0));
      rv.bad_val = ($urandom_range(1, 0) != 0) ? pat[$urandom_range(3, 0)] : 16'($urandom);
      rv.exp_err = 0;
      rv.exp_faddr = 0;
      for (int a = 0; a < 4; a++) begin
        if (rv.mask[a] && rv.bad_val != pat[a]) begin
          if (rv.exp_err == 0) rv.exp_faddr = a;
          rv.exp_err++;
        end
      end
      run_vec(rv, $sformatf("rand%0d", r));
    end

    // Watchdog: controller never completes the second write.
    busy_lo = 2;
    busy_hi = 2;
    bad_mask = '0;
    base = log_q.size();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (log_q.size() < base + 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("tmo.second_trigger_seen", 64'(log_q.size() - base), 64'd2);
    force_low = 1'b1;
    n = 1;
    while (!fail && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("tmo.latency_in_range", {63'd0, (n >= TOUT && n <= TOUT + 2)}, 64'd1);
    check("tmo.flags", {60'd0, timeout, fail, pass, busy}, {60'd0, 4'b1100});
    repeat (10) @(negedge clk);
    check("tmo.no_more_triggers", 64'(log_q.size() - base), 64'd2);
    force_low = 1'b0;
    repeat (5) @(negedge clk);

    // Reset during the read pass, then a clean rerun.
    base = log_q.size();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (log_q.size() < base + WC + 1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("rst.read_pass_reached", {63'd0, (log_q.size() >= base + WC + 1)}, 64'd1);
    @(negedge clk);
    rst_ = 1'b0;
    #1;
    check("rst.outputs_immediate", {cmdTrigger, cmdAddr, cmdWrite, cmdWriteData, busy, pass,
                                    fail, timeout, errCount, failAddr}, 64'd0);
    base = log_q.size();
    repeat (6) @(negedge clk);
    check("rst.no_trigger_in_reset", 64'(log_q.size() - base), 64'd0);
    rst_ = 1'b1;
    n = 0;
    while (!cmdDone && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("rst.no_trigger_after_release", 64'(log_q.size() - base), 64'd0);
    run_vec(vecs[0], "rerun");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
